// File: rtl/pressure_pkg.sv
// Shared types and constants for the over-pressure alarm filter.
package pressure_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ALARM    = 2'd2,
    ST_CLEARING = 2'd3
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pressure_alarm_fsm.sv
// Persistence filter for the registered over-pressure bit: raises a debounced
// alarm, keeps a sticky flag until acknowledged, and counts alarm events.
module pressure_alarm_fsm
  import pressure_pkg::*;
#(
  parameter int ASSERT_CNT = 4,
  parameter int CLEAR_CNT  = 4,
  parameter int EVT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             over_p,
  input  logic             ack,
  output logic             alarm,
  output logic             alarm_latched,
  output logic             pending,
  output logic [EVT_W-1:0] event_count,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] ASSERT_LIM = CNT_W'(ASSERT_CNT);
  localparam logic [CNT_W-1:0] CLEAR_LIM  = CNT_W'(CLEAR_CNT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alarm_q, pending_q, latched_q;
  logic             new_event;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (over_p) begin
            state_d = ST_ARMING;
            cnt_d   = 8'd1;
          end else begin
            cnt_d   = '0;
          end
        end
        ST_ARMING: begin
          if (!over_p) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q + 8'd1 == ASSERT_LIM) begin
            state_d = ST_ALARM;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 8'd1;
          end
        end
        ST_ALARM: begin
          if (!over_p) begin
            state_d = ST_CLEARING;
            cnt_d   = 8'd1;
          end
        end
        ST_CLEARING: begin
          // A high sample while clearing resumes the same alarm, not a new one.
          if (over_p) begin
            state_d = ST_ALARM;
            cnt_d   = '0;
          end else if (cnt_q + 8'd1 == CLEAR_LIM) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign new_event = (state_q == ST_ARMING) && (state_d == ST_ALARM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      alarm_q   <= 1'b0;
      pending_q <= 1'b0;
      latched_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alarm_q   <= (state_d == ST_ALARM) || (state_d == ST_CLEARING);
      pending_q <= (state_d == ST_ARMING);
      // Set beats clear; ack is honoured only once the alarm is gone.
      if (new_event) begin
        latched_q <= 1'b1;
      end else if (ack && ((state_d == ST_IDLE) || (state_d == ST_ARMING))) begin
        latched_q <= 1'b0;
      end
    end
  end

  sat_counter #(
    .WIDTH(EVT_W)
  ) u_evt_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .inc_i  (new_event),
    .clr_i  (1'b0),
    .count_o(event_count)
  );

  assign alarm         = alarm_q;
  assign pending       = pending_q;
  assign alarm_latched = latched_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pressure_alarm_fsm.sv
// Directed-vector bench for pressure_alarm_fsm (default build plus a 2-bit event counter build).
module tb_pressure_alarm_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       over_p = 1'b0;
  logic       ack = 1'b0;

  logic       alarm, alarm_latched, pending;
  logic [7:0] event_count;
  logic [1:0] state;

  logic       s_alarm, s_latched, s_pending;
  logic [1:0] s_event_count;
  logic [1:0] s_state;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pressure_alarm_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .over_p       (over_p),
    .ack          (ack),
    .alarm        (alarm),
    .alarm_latched(alarm_latched),
    .pending      (pending),
    .event_count  (event_count),
    .state        (state)
  );

  pressure_alarm_fsm #(.EVT_W(2)) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .over_p       (over_p),
    .ack          (ack),
    .alarm        (s_alarm),
    .alarm_latched(s_latched),
    .pending      (s_pending),
    .event_count  (s_event_count),
    .state        (s_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %-22s obs=%0d exp=%0d", tag, obs, exp);
    end else begin
      $display("FAIL %-22s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset held with over_p high
    over_p = 1'b1;
    step(2);
    check("rst_state", state, 0);
    check("rst_alarm", alarm, 0);
    check("rst_latched", alarm_latched, 0);
    check("rst_pending", pending, 0);
    check("rst_evt", event_count, 0);
    reset = 1'b1;

    // Clean assert
    step(3);
    check("arm3_alarm", alarm, 0);
    check("arm3_pending", pending, 1);
    step(1);
    check("arm4_state", state, 2);
    check("arm4_alarm", alarm, 1);
    check("arm4_latched", alarm_latched, 1);
    check("arm4_evt", event_count, 1);
    check("arm4_sat_evt", s_event_count, 1);

    // ack while alarm active is ignored
    ack = 1'b1;
    step(1);
    check("ack_in_alarm", alarm_latched, 1);
    ack = 1'b0;

    // Chatter during clear
    over_p = 1'b0;
    step(3);
    check("clr3_state", state, 3);
    check("clr3_alarm", alarm, 1);
    over_p = 1'b1;
    step(1);
    check("chat_state", state, 2);
    check("chat_alarm", alarm, 1);
    check("chat_evt", event_count, 1);

    // Clean clear
    over_p = 1'b0;
    step(3);
    check("clr_b3_alarm", alarm, 1);
    step(1);
    check("clr4_state", state, 0);
    check("clr4_alarm", alarm, 0);
    check("clr4_latched", alarm_latched, 1);

    // ack in IDLE clears the sticky flag
    ack = 1'b1;
    step(1);
    check("ack_idle", alarm_latched, 0);
    ack = 1'b0;

    // Glitch rejection
    over_p = 1'b1;
    step(3);
    check("gl_pend_a", pending, 1);
    over_p = 1'b0;
    step(1);
    check("gl_pend_low", pending, 0);
    check("gl_state_low", state, 0);
    over_p = 1'b1;
    step(3);
    check("gl_pend_b", pending, 1);
    check("gl_alarm", alarm, 0);
    check("gl_evt", event_count, 1);
    over_p = 1'b0;
    step(1);

    // ack coincident with new alarm entry: set wins
    over_p = 1'b1;
    step(3);
    check("sw_latched_pre", alarm_latched, 0);
    ack = 1'b1;
    step(1);
    check("sw_latched", alarm_latched, 1);
    check("sw_evt", event_count, 2);
    ack = 1'b0;

    // enable=0 during ALARM
    enable = 1'b0;
    step(1);
    check("en0_state", state, 0);
    check("en0_alarm", alarm, 0);
    check("en0_pending", pending, 0);
    check("en0_latched", alarm_latched, 1);
    check("en0_evt", event_count, 2);
    ack = 1'b1;
    step(1);
    check("en0_ack", alarm_latched, 0);
    ack = 1'b0;
    enable = 1'b1;

    // Asynchronous reset mid-ARMING
    step(2);
    check("mid_state_pre", state, 1);
    #2 reset = 1'b0;
    #1;
    check("async_state", state, 0);
    check("async_pending", pending, 0);
    check("async_evt", event_count, 0);
    step(1);
    reset = 1'b1;

    // Saturation on the 2-bit counter build
    for (int e = 0; e < 5; e++) begin
      over_p = 1'b1;
      step(4);
      over_p = 1'b0;
      step(4);
      check("evt_full", event_count, e + 1);
      check("evt_sat", s_event_count, (e + 1 > 3) ? 3 : e + 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
